ps2_keyboard_rx: RTL
====================

Name: ps2_keyboard_rx

Overview:
Parametrised successor to the existing PS/2 receiver. It synchronises and de-glitches ps2_clk and ps2_data, then receives full 11-bit frames. Start, odd-parity and stop bits are checked, and a per-bit watchdog aborts stalled frames. The E0 (extended) and F0 (break) prefixes are folded into single key events, which are buffered in a FIFO with a valid/ready handshake toward game-logic input handling. A legacy last_key output is kept.

Parameters:
SYNC_STAGES, 3, flip-flop stages on ps2_clk and ps2_data (minimum 2)
FILTER_CYCLES, 8, consecutive equal synchronised ps2_clk samples required before the filtered clock changes
TIMEOUT_CYCLES, 20000, clk cycles without a filtered falling edge mid-frame before the frame is aborted (200 us at 100 MHz)
FIFO_DEPTH, 8, event FIFO entries; power of two, minimum 2

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock pin
ps2_data  in  1  raw PS/2 data pin
event_valid  out  1  FIFO head holds an event
event_ready  in  1  consumer accepts the head event when event_valid is also high
event_code  out  8  scan code of the head event
event_ext  out  1  head event was preceded by E0
event_break  out  1  head event was preceded by F0 (key release)
fifo_count  out  log2(FIFO_DEPTH)+1  number of occupied entries
frame_err  out  1  one-cycle pulse on start, parity or stop error, or on timeout
overflow  out  1  one-cycle pulse when a decoded event is dropped because the FIFO is full
last_key  out  8  code of the most recently pushed event

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - All outputs 0; FIFO empty; frame FSM IDLE; prefix flags clear.
  - Synchronisers and the filtered clock reset to 1 (idle bus).
- Input conditioning:
  - ps2_clk and ps2_data each pass through SYNC_STAGES flip-flops.
  - The filtered clock changes only after FILTER_CYCLES consecutive equal synchronised samples.
  - A falling edge is a 1-to-0 transition of the filtered clock, flagged for exactly one cycle.
  - Data is sampled from the synchronised ps2_data in that same cycle.
- Frame FSM, states IDLE and RECV, with bit index 0..10:
  - IDLE: on a falling edge, sample bit 0 and enter RECV with index 1. The start bit is not checked until the frame ends.
  - RECV, per falling edge: indices 1-8 shift data LSB first, index 9 is parity, index 10 is stop.
  - On the index-10 edge (cycle T), the frame is evaluated and the FSM returns to IDLE in the same edge.
  - A frame is valid when start = 0, the 8 data bits plus the parity bit contain an odd number of 1s, and stop = 1.
  - Watchdog counter clears on every falling edge and counts only in RECV. On reaching TIMEOUT_CYCLES: frame_err pulses, the FSM returns to IDLE, the partial byte is discarded and prefix flags are cleared.
  - An invalid frame pulses frame_err at T+1, clears prefix flags and pushes nothing.
- Prefix decoder, on each valid byte at T+1:
  - E0: sets ext_pending.
  - F0: sets brk_pending.
  - Any other byte (including E1, AA, FA, FE): pushes {ext_pending, brk_pending, byte}, updates last_key, and clears both flags.
  - Prefixes in either order accumulate (E0 F0 xx gives ext=1, brk=1).
- Latency: event_valid rises at T+2 when the FIFO was empty. Overall pin-to-edge delay is roughly SYNC_STAGES+FILTER_CYCLES cycles.
- FIFO:
  - First-word-fall-through: event_code, event_ext and event_break show the head entry whenever event_valid is high.
  - Pop when event_valid && event_ready.
  - Push when not full. When full, push is also allowed in a cycle that pops.
  - Push while full without a pop: the event is dropped, overflow pulses, and FIFO contents and fifo_count are unchanged. last_key still updates.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - event_ready while empty has no effect.
- Reset mid-frame or mid-FIFO: everything returns to reset values on the next edge, pending events are lost, and the next frame is received normally.

Test Plan:
- Frame 0,0x1C LSB-first,parity 0,stop 1 -> at T+2 event_valid=1, code=0x1C, ext=0, break=0; last_key=0x1C; frame_err never pulses.
- Frames F0,1C with event_ready=0 -> one event: code=0x1C, break=1, fifo_count=1. Then frames E0,F0,75 -> second event: code=0x75, ext=1, break=1, fifo_count=2.
- Frame 0x1C with parity bit inverted, then frame 0x32 -> frame_err pulses once at T+1 and nothing is pushed. The next frame gives code=0x32.
- 5 data bits then ps2_clk held high for 20000 cycles -> frame_err pulses, FSM in IDLE. A following full frame 0x29 decodes correctly.
- FIFO_DEPTH+1 make codes with event_ready=0 -> fifo_count=8, overflow pulses once on the 9th. Then event_ready=1 drains 8 events in order; the dropped code is absent.
- 1-cycle glitches on ps2_clk shorter than FILTER_CYCLES -> no bit shift. Separately, rst asserted after bit 4 -> outputs 0 next cycle, and the next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: pin conditioning, 11-bit frame checks with watchdog,
// E0/F0 prefix folding into key events, and a first-word-fall-through event FIFO.
module ps2_keyboard_rx #(
  parameter int SYNC_STAGES    = 3,
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          event_valid,
  input  logic                          event_ready,
  output logic [7:0]                    event_code,
  output logic                          event_ext,
  output logic                          event_break,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [7:0]                    last_key
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int FCW = $clog2(FILTER_CYCLES + 1);
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ev_t;

  typedef enum logic {IDLE, RECV} state_t;

  // ---------------- input conditioning ----------------
  logic [SYNC_STAGES-1:0] csync_q, csync_d, dsync_q, dsync_d;
  logic [FCW-1:0]         fcnt_q, fcnt_d;
  logic                   filt_q, filt_d, fall_q, fall_d;
  logic                   clk_s, data_s;

  assign clk_s  = csync_q[SYNC_STAGES-1];
  assign data_s = dsync_q[SYNC_STAGES-1];

  always_comb begin
    csync_d = {csync_q[SYNC_STAGES-2:0], ps2_clk};
    dsync_d = {dsync_q[SYNC_STAGES-2:0], ps2_data};
    filt_d  = filt_q;
    fcnt_d  = '0;
    // the filtered clock follows only after FILTER_CYCLES disagreeing samples in a row
    if (clk_s != filt_q) begin
      if (fcnt_q == FCW'(FILTER_CYCLES - 1)) filt_d = clk_s;
      else                                   fcnt_d = fcnt_q + FCW'(1);
    end
    fall_d = filt_q & ~filt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csync_q <= '1;
      dsync_q <= '1;
      filt_q  <= 1'b1;
      fcnt_q  <= '0;
      fall_q  <= 1'b0;
    end else begin
      csync_q <= csync_d;
      dsync_q <= dsync_d;
      filt_q  <= filt_d;
      fcnt_q  <= fcnt_d;
      fall_q  <= fall_d;
    end
  end

  // ---------------- frame FSM with watchdog ----------------
  state_t         state_q;
  logic [3:0]     idx_q;
  logic [7:0]     shift_q, byte_q;
  logic           start_q, par_q;
  logic [WDW-1:0] wd_q;
  logic           done_q, abort_q, frame_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      shift_q     <= '0;
      byte_q      <= '0;
      start_q     <= 1'b0;
      par_q       <= 1'b0;
      wd_q        <= '0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      frame_err_q <= 1'b0;
      if (fall_q || state_q == IDLE) wd_q <= '0;
      else                           wd_q <= wd_q + WDW'(1);
      case (state_q)
        IDLE: if (fall_q) begin
          start_q <= data_s;
          idx_q   <= 4'd1;
          state_q <= RECV;
        end
        RECV: if (fall_q) begin
          idx_q <= idx_q + 4'd1;
          if (idx_q <= 4'd8) shift_q <= {data_s, shift_q[7:1]};
          else if (idx_q == 4'd9) par_q <= data_s;
          else begin
            state_q <= IDLE;
            if (!start_q && (^{shift_q, par_q}) && data_s) begin
              done_q <= 1'b1;
              byte_q <= shift_q;
            end else begin
              abort_q     <= 1'b1;
              frame_err_q <= 1'b1;
            end
          end
        end else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
          state_q     <= IDLE;
          abort_q     <= 1'b1;
          frame_err_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------- prefix decoder and event FIFO ----------------
  ev_t           mem_q [FIFO_DEPTH];
  ev_t           head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ext_q, ext_d, brk_q, brk_d, overflow_q, overflow_d;
  logic [7:0]    last_key_q, last_key_d;
  logic          is_prefix, push_req, push, pop, full;

  always_comb begin
    is_prefix  = (byte_q == 8'hE0) || (byte_q == 8'hF0);
    full       = (cnt_q == (AW+1)'(FIFO_DEPTH));
    pop        = (cnt_q != '0) && event_ready;
    push_req   = done_q && !is_prefix;
    // a full FIFO still takes the event when the head leaves in the same cycle
    push       = push_req && (!full || pop);
    overflow_d = push_req && !push;
    ext_d      = ext_q;
    brk_d      = brk_q;
    last_key_d = last_key_q;
    if (abort_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (done_q) begin
      if (byte_q == 8'hE0)      ext_d = 1'b1;
      else if (byte_q == 8'hF0) brk_d = 1'b1;
      else begin
        ext_d      = 1'b0;
        brk_d      = 1'b0;
        last_key_d = byte_q;
      end
    end
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!push && pop) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      overflow_q <= 1'b0;
      last_key_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      overflow_q <= overflow_d;
      last_key_q <= last_key_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{ext: ext_q, brk: brk_q, code: byte_q};
  end

  // storage is not reset, so the head is masked while empty
  assign head        = mem_q[rd_ptr_q];
  assign event_valid = (cnt_q != '0);
  assign event_code  = event_valid ? head.code : 8'h00;
  assign event_ext   = event_valid & head.ext;
  assign event_break = event_valid & head.brk;
  assign fifo_count  = cnt_q;
  assign frame_err   = frame_err_q;
  assign overflow    = overflow_q;
  assign last_key    = last_key_q;
endmodule
